// File: rtl/kpg_prefix_seq_if.sv
// Start/result valid-ready bundle for the iterative KPG prefix adder.
// The adder itself is the slave; whoever issues operations is the master.
interface kpg_prefix_seq_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, busy
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, busy
  );
endinterface

// File: rtl/kpg_prefix_seq.sv
// Iterative Kogge-Stone KPG prefix adder: one row of combine cells reused
// over log2(WIDTH) cycles, with a start/result valid-ready handshake.
module kpg_prefix_seq #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  kpg_prefix_seq_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b10;
  localparam logic [1:0] KPG_G = 2'b11;

  typedef enum logic [1:0] {IDLE, PREFIX, DONE} state_t;

  state_t                            state_q;
  logic [LVL_W-1:0]                  level_q;
  logic [WIDTH-1:0][1:0]             vec_q;
  logic [WIDTH-1:0][1:0]             vec_d;
  logic [WIDTH-1:0][1:0]             vec_load;
  logic [LEVELS-1:0][WIDTH-1:0][1:0] stage;
  logic [WIDTH-1:0]                  a_q;
  logic [WIDTH-1:0]                  b_q;
  logic [WIDTH-1:0]                  sum_q;
  logic [WIDTH-1:0]                  sum_d;
  logic [WIDTH-1:0]                  carry_d;
  logic                              cin_q;
  logic                              cout_q;
  logic                              res_valid_q;
  logic                              start_ready_q;
  logic                              busy_q;

  // Generate-or-propagate encoding collapses to {a|b, a&b}, so 2'b01 cannot arise.
  function automatic logic [1:0] kpg(input logic ai, input logic bi);
    return {ai | bi, ai & bi};
  endfunction

  function automatic logic [1:0] combine(input logic [1:0] cur, input logic [1:0] prev);
    return (cur == KPG_P) ? prev : cur;
  endfunction

  // Carry-in is folded into bit 0 so the prefix network alone resolves every carry.
  always_comb begin
    vec_load = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vec_load[i] = kpg(bus.a[i], bus.b[i]);
    end
    vec_load[0] = combine(kpg(bus.a[0], bus.b[0]), bus.cin ? KPG_G : KPG_K);
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_cmb
        assign stage[k][i] = combine(vec_q[i], vec_q[i - (1 << k)]);
      end else begin : g_pass
        assign stage[k][i] = vec_q[i];
      end
    end
  end

  // After the last level every entry is K or G; its low bit is the carry out of that bit.
  always_comb begin
    vec_d      = stage[level_q];
    carry_d    = '0;
    carry_d[0] = cin_q;
    for (int i = 1; i < WIDTH; i++) begin
      carry_d[i] = vec_d[i-1][0];
    end
    sum_d = a_q ^ b_q ^ carry_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      level_q       <= '0;
      vec_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid && start_ready_q) begin
            a_q           <= bus.a;
            b_q           <= bus.b;
            cin_q         <= bus.cin;
            vec_q         <= vec_load;
            level_q       <= '0;
            state_q       <= PREFIX;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        PREFIX: begin
          vec_q <= vec_d;
          if (level_q == LVL_W'(LEVELS - 1)) begin
            sum_q       <= sum_d;
            cout_q      <= vec_d[WIDTH-1][0];
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            level_q <= level_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          res_valid_q   <= 1'b0;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_kpg_prefix_seq.sv
// Directed and random checks of the iterative KPG prefix adder at WIDTH=16
// and WIDTH=8, with expected sums taken from plain integer addition.
module tb_kpg_prefix_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  kpg_prefix_seq_if #(.WIDTH(16)) bus16 ();
  kpg_prefix_seq_if #(.WIDTH(8))  bus8 ();

  kpg_prefix_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  kpg_prefix_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Counts illegal 2'b01 entries, and also leftover P entries when noP is set.
  function automatic int countBad(input logic [31:0] v, input int w, input bit noP);
    int n = 0;
    for (int i = 0; i < w; i++) begin
      if (v[2*i +: 2] === 2'b01) n++;
      if (noP && v[2*i +: 2] === 2'b10) n++;
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    bus16.a = av;
    bus16.b = bv;
    bus16.cin = cv;
    bus16.start_valid = 1'b1;
    tick();
    bus16.start_valid = 1'b0;
  endtask

  task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    bus8.a = av;
    bus8.b = bv;
    bus8.cin = cv;
    bus8.start_valid = 1'b1;
    tick();
    bus8.start_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; lat counts cycles from the accept cycle.
  task automatic waitResult16(output int lat, output int vecBad, output bit busyOk);
    lat = 1;
    vecBad = 0;
    busyOk = 1'b1;
    while (bus16.res_valid !== 1'b1 && lat < 20) begin
      if (bus16.start_ready !== 1'b0 || bus16.busy !== 1'b1) busyOk = 1'b0;
      vecBad += countBad(32'(dut16.vec_q), 16, 1'b0);
      tick();
      lat++;
    end
    if (bus16.start_ready !== 1'b0 || bus16.busy !== 1'b1) busyOk = 1'b0;
    vecBad += countBad(32'(dut16.vec_q), 16, 1'b1);
  endtask

  task automatic waitResult8(output int lat, output int vecBad);
    lat = 1;
    vecBad = 0;
    while (bus8.res_valid !== 1'b1 && lat < 20) begin
      vecBad += countBad(32'(dut8.vec_q), 8, 1'b0);
      tick();
      lat++;
    end
    vecBad += countBad(32'(dut8.vec_q), 8, 1'b1);
  endtask

  task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [15:0] expSum, input logic expCout);
    int lat;
    int vecBad;
    bit busyOk;
    bus16.res_ready = 1'b1;
    applyStimulus(av, bv, cv);
    waitResult16(lat, vecBad, busyOk);
    checkOutput({tag, ":lat"}, lat, 5);
    checkOutput({tag, ":busy"}, 32'(busyOk), 1);
    checkOutput({tag, ":vec"}, vecBad, 0);
    checkOutput({tag, ":sum"}, bus16.sum, expSum);
    checkOutput({tag, ":cout"}, bus16.cout, expCout);
    tick();
    checkOutput({tag, ":idle"}, {bus16.res_valid, bus16.start_ready}, 2'b01);
  endtask

  initial begin
    int          lat;
    int          vecBad;
    bit          busyOk;
    int          stall;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] exp17;
    logic [8:0]  exp9;

    total = 0;
    bad = 0;
    rst = 1'b1;
    bus16.start_valid = 1'b1;
    bus16.a = 16'h0005;
    bus16.b = 16'h0005;
    bus16.cin = 1'b0;
    bus16.res_ready = 1'b1;
    bus8.start_valid = 1'b1;
    bus8.a = 8'h03;
    bus8.b = 8'h04;
    bus8.cin = 1'b1;
    bus8.res_ready = 1'b1;

    // Reset held two cycles with start_valid asserted.
    tick();
    tick();
    checkOutput("rst:res_valid", bus16.res_valid, 0);
    checkOutput("rst:sum", bus16.sum, 0);
    checkOutput("rst:cout", bus16.cout, 0);
    checkOutput("rst:busy", bus16.busy, 0);
    checkOutput("rst:start_ready", bus16.start_ready, 1);
    checkOutput("rst:busy8", bus8.busy, 0);
    rst = 1'b0;
    bus16.start_valid = 1'b0;
    bus8.start_valid = 1'b0;
    tick();
    checkOutput("rst:no_accept", {bus16.busy, bus16.start_ready}, 2'b01);

    // Basic ripple through the low byte, then full propagate chains.
    runOp("add00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    runOp("chain_c1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    runOp("chain_c0", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0);

    // Backpressure with a competing start request held high.
    bus16.res_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    waitResult16(lat, vecBad, busyOk);
    checkOutput("bp:lat", lat, 5);
    bus16.a = 16'h0F0F;
    bus16.b = 16'h0101;
    bus16.cin = 1'b1;
    bus16.start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp:hold", {bus16.res_valid, bus16.start_ready, bus16.cout, bus16.sum},
                  {1'b1, 1'b0, 1'b0, 16'h3333});
    end
    bus16.res_ready = 1'b1;
    tick();
    checkOutput("bp:release", {bus16.res_valid, bus16.start_ready, bus16.sum}, {2'b01, 16'h3333});
    tick();
    bus16.start_valid = 1'b0;
    checkOutput("bp:accept", {bus16.busy, bus16.start_ready}, 2'b10);
    waitResult16(lat, vecBad, busyOk);
    checkOutput("bp:lat2", lat, 5);
    checkOutput("bp:sum2", {bus16.cout, bus16.sum}, {1'b0, 16'h1011});
    tick();

    // Reset during the level-2 cycle of PREFIX discards the operation.
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst:state", {bus16.res_valid, bus16.busy, bus16.start_ready}, 3'b001);
    checkOutput("midrst:result", {bus16.cout, bus16.sum}, 17'h0);
    busyOk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus16.res_valid !== 1'b0) busyOk = 1'b0;
    end
    checkOutput("midrst:no_pulse", 32'(busyOk), 1);
    runOp("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Random operations with random result stalls, WIDTH=16.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      bus16.res_ready = (stall == 0);
      applyStimulus(ra, rb, rc);
      waitResult16(lat, vecBad, busyOk);
      exp17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      checkOutput("r16:lat", lat, 5);
      checkOutput("r16:vec", vecBad, 0);
      checkOutput("r16:res", {bus16.cout, bus16.sum}, exp17);
      for (int s = 0; s < stall; s++) tick();
      bus16.res_ready = 1'b1;
      tick();
    end

    // Random operations with random result stalls, WIDTH=8.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      bus8.res_ready = (stall == 0);
      applyStimulus8(ra[7:0], rb[7:0], rc);
      waitResult8(lat, vecBad);
      exp9 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'h0, rc};
      checkOutput("r8:lat", lat, 4);
      checkOutput("r8:vec", vecBad, 0);
      checkOutput("r8:res", {bus8.cout, bus8.sum}, exp9);
      for (int s = 0; s < stall; s++) tick();
      bus8.res_ready = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kpg_prefix_seq.md
Name: kpg_prefix_seq

Overview:
Iterative KPG (kill/propagate/generate) prefix-adder sequencer for the integer execution slots. It holds one row of WIDTH KPG combine cells and reuses that row across log2(WIDTH) cycles, one prefix level per cycle with span doubling (Kogge-Stone order). It uses a start/result valid-ready handshake, so an issue slot can trade latency for area compared with a fully unrolled prefix tree.

Parameters:
WIDTH, 16, operand width; power of two, >= 2.
LEVELS, log2(WIDTH), number of prefix levels; derived localparam, not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start_valid  input  1  operands a, b, cin are valid.
start_ready  output  1  block can accept an operation (high only in IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in.
res_valid  output  1  sum and cout are valid.
res_ready  input  1  consumer accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in PREFIX or DONE.

Behaviour:
- Encoding: K=2'b00, G=2'b11, P=2'b10.
  - Per-bit generation: a[i],b[i] = 00 -> K, 11 -> G, otherwise P.
  - Combine(cur, prev): cur K -> K; cur G -> G; cur P -> prev.
  - Encoding 2'b01 never appears in state; the bench asserts this.
- Reset: state=IDLE, level counter=0, KPG vector=0, sum=0, cout=0, res_valid=0, busy=0, start_ready=1.
- rst has priority over every other input.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready (accept, cycle T):
    - latch a, b, cin;
    - load vector v[i]=kpg(a[i],b[i]) for i>=1;
    - load v[0]=Combine(kpg(a[0],b[0]), cin ? G : K);
    - level=0; go to PREFIX.
  - start_valid without acceptance has no effect.
- PREFIX:
  - Each cycle applies level k=level, span s=2^k, all entries updated simultaneously from the old vector.
  - v[i] <= Combine(v[i], v[i-s]) for i>=s; v[i] unchanged for i<s.
  - level increments each cycle. After the cycle applying k=LEVELS-1, go to DONE.
  - PREFIX occupies cycles T+1..T+LEVELS.
- Carry and sum formation, on entry to DONE:
  - Every v[i] is K or G at this point.
  - Carry into bit 0 is the latched cin; carry into bit i>0 is v[i-1][0].
  - sum[i] = a[i]^b[i]^carry_in[i]; cout = v[WIDTH-1][0].
  - sum and cout are registered on the same edge that enters DONE.
- DONE:
  - res_valid=1 from cycle T+LEVELS+1 (latency LEVELS+1 from the accept edge; 5 cycles for WIDTH=16).
  - sum, cout and res_valid are held stable until res_ready is sampled high.
  - On res_valid && res_ready: res_valid<=0, state<=IDLE. start_ready rises the following cycle; no same-cycle accept in DONE.
- Throughput: one operation per LEVELS+2 cycles minimum.
- start_ready=0 and busy=1 throughout PREFIX and DONE; start_valid is ignored there.
- sum and cout keep their last value after the result handshake and are only updated on entry to DONE.
- Reset mid-operation (PREFIX or DONE): the operation is discarded. Next cycle state=IDLE, res_valid=0, sum=0, cout=0. No stale result is ever presented.
- The combine result does not depend on res_ready; backpressure only stalls in DONE.

Test Plan:
1. Reset: assert rst 2 cycles with start_valid=1 -> res_valid=0, sum=0, cout=0, busy=0, start_ready=1; no accept occurs during reset.
2. WIDTH=16, a=0x00FF, b=0x0001, cin=0, accepted at T -> res_valid first high at T+5, sum=0x0100, cout=0; start_ready low T+1..T+5.
3. Full propagate chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. a=0xFFFF, b=0x0000, cin=0 -> sum=0xFFFF, cout=0.
4. Backpressure: result ready, res_ready held low 3 cycles while start_valid=1 with new operands -> sum/cout/res_valid stable, no accept. res_ready high -> IDLE next cycle, then the new op is accepted.
5. Reset mid-op: accept a=0x1234, b=0x4321, assert rst during PREFIX level 2 -> IDLE next cycle, res_valid never pulses. The following op a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
6. Random regression: 1000 random ops each at WIDTH=8 (latency 4) and WIDTH=16 with random res_ready stalls -> {cout,sum} == a+b+cin every time; vector never contains 2'b01; no P remains after the final level.
